markov_player: RTL
==================

Name: markov_player

Overview:
- Computer opponent that predicts the user's next rock/paper/scissor move from a first-order Markov transition table.
- Outputs the move that beats the prediction.
- Sits beside the random and reinforcement players; its choice feeds the game's computer-choice mux.
- Consumes each resolved round's user move and produces the next computer choice.

Parameters:
- COUNT_W, 4: width of each transition counter (saturating with row halving).
- LFSR_SEED, 8'hA5: reset seed of tie-break LFSR (used only with MARKOV_RANDOM_TIE_EN).

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- reset  in  1  asynchronous, active-low reset.
- round_valid  in  1  one-cycle pulse: a round has resolved and user_move is valid.
- user_move  in  2  user's move that round: 00 rock, 01 scissor, 10 paper; 11 is illegal.
- ready  out  1  high in IDLE; round_valid is accepted only when ready=1.
- choice  out  2  computer's next move, same encoding, registered.
- choice_valid  out  1  one-cycle pulse when choice has been updated.
- invalid_move  out  1  one-cycle pulse when an accepted round carried user_move=11.

Behaviour:
- State: 3x3 table T[prev][next] of COUNT_W-bit counters; prev_move (2b); have_prev flag; FSM IDLE/UPDATE/PREDICT.
- Reset (async, any state): all T=0, have_prev=0, prev_move=00, FSM=IDLE, choice=00, choice_valid=0, invalid_move=0, ready=1.
- IDLE, round_valid=1 at edge N:
  - If user_move=11: invalid_move=1 after edge N for one cycle; no other state change; stay IDLE.
  - Otherwise: latch user_move as cur; go to UPDATE; ready=0.
- UPDATE, edge N+1:
  - If have_prev=1: increment T[prev_move][cur].
  - If that counter already equals 2^COUNT_W-1: first right-shift all three counters of row prev_move by 1, then increment the target. Result: (max>>1)+1; other row entries halved.
  - If have_prev=0: table unchanged.
  - Always: prev_move=cur, have_prev=1. Go to PREDICT.
- PREDICT, edge N+2:
  - predicted = argmax over T[cur][*] (the row of the just-received move).
  - Tie rule: lowest encoding wins (rock 00 < scissor 01 < paper 10).
  - choice = beater(predicted): rock→paper 10, scissor→rock 00, paper→scissor 01.
  - choice_valid=1 for the cycle following edge N+2; FSM→IDLE, ready=1.
- Latency: round_valid to choice_valid is 2 edges; ready low for exactly 2 cycles.
- round_valid while ready=0 is ignored (no table change, no pulse); the upstream must wait for ready.
- choice holds its value between predictions and is never 11.
- Arithmetic: argmax compares unsigned COUNT_W-bit values; no counter ever wraps to 0.

Optional Feature:
- Macro MARKOV_RANDOM_TIE_EN.
- Defined:
  - 8-bit Fibonacci LFSR (taps 8,6,5,4), reset to LFSR_SEED, advances every clock.
  - In PREDICT, ties among maximal entries are broken by LFSR[1:0] mod (number of tied entries), indexing the tied set in ascending encoding order.
  - All-zero row: any of the three moves may be predicted.
- Not defined: deterministic lowest-encoding tie rule; no LFSR logic present.

Test Plan:
- Reset asserted mid-UPDATE → immediately ready=1, choice=00, choice_valid=0; table probe all zero; next round behaves as first round.
- After reset, single round rock (00) → choice_valid pulse 2 edges later, choice=10 (all-zero row ties to rock); ready low exactly 2 cycles.
- Rounds R,S,R (00,01,00) → choices 10, 10, 00 (after third round, T[R][S]=1 predicts scissor, beaten by rock).
- COUNT_W=2, five rounds of rock → T[R][R] probe reads 1,2,3 after rounds 2–4, then 2 after round 5 (halve 3→1, +1); choice=10 throughout.
- user_move=11 with round_valid in IDLE → invalid_move pulse, no choice_valid, choice and table unchanged; round_valid pulsed while ready=0 → ignored, no extra choice_valid.
- With MARKOV_RANDOM_TIE_EN, LFSR_SEED=8'h01: an all-zero-row tie across 100 first-rounds with varied timing → choice values {00,01,10} all appear; choice never 11.

Source files
------------

// File: rtl/markov_player_if.sv
// Round/choice handshake between the game core and the Markov opponent.
interface markov_player_if;
    logic       round_valid;
    logic [1:0] user_move;
    logic       ready;
    logic [1:0] choice;
    logic       choice_valid;
    logic       invalid_move;

    modport master (
        output round_valid, user_move,
        input  ready, choice, choice_valid, invalid_move
    );

    modport slave (
        input  round_valid, user_move,
        output ready, choice, choice_valid, invalid_move
    );
endinterface

// File: rtl/markov_player.sv
// First-order Markov rock/paper/scissor opponent; plays the beater of the prediction.
// Optional MARKOV_RANDOM_TIE_EN: LFSR-driven tie-break among maximal row entries.
module markov_player #(
    parameter int          COUNT_W   = 4,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic      clock,
    input  logic      reset,
    markov_player_if.slave bus
);
    typedef enum logic [1:0] {IDLE, UPDATE, PREDICT} state_t;

    state_t                    state;
    logic [8:0][COUNT_W-1:0]   tbl;
    logic [1:0]                prev_move;
    logic [1:0]                cur;
    logic                      have_prev;

    logic [3:0]                pbase;
    logic [3:0]                cbase;
    logic [3:0]                tgt;
    logic                      sat;
    logic [COUNT_W-1:0]        r0, r1, r2;
    logic [1:0]                pred;

    // Flat index of the first entry of a row: row * 3.
    function automatic logic [3:0] row_base(input logic [1:0] m);
        case (m)
            2'd0:    row_base = 4'd0;
            2'd1:    row_base = 4'd3;
            default: row_base = 4'd6;
        endcase
    endfunction

    function automatic logic [1:0] beater(input logic [1:0] m);
        case (m)
            2'b00:   beater = 2'b10;
            2'b01:   beater = 2'b00;
            default: beater = 2'b01;
        endcase
    endfunction

    assign pbase = row_base(prev_move);
    assign cbase = row_base(cur);
    assign tgt   = pbase + {2'b00, cur};
    assign sat   = (tbl[tgt] == {COUNT_W{1'b1}});
    assign r0    = tbl[cbase];
    assign r1    = tbl[cbase + 4'd1];
    assign r2    = tbl[cbase + 4'd2];

`ifdef MARKOV_RANDOM_TIE_EN
    logic [7:0]         lfsr;
    logic [COUNT_W-1:0] mx;
    logic [2:0]         tie;
    logic [1:0]         ntie;
    logic [1:0]         k;
    logic [1:0]         seen;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    // Pick the k-th tied maximum in ascending encoding order.
    always_comb begin
        mx = r0;
        if (r1 > mx) mx = r1;
        if (r2 > mx) mx = r2;
        tie  = {r2 == mx, r1 == mx, r0 == mx};
        ntie = 2'({1'b0, tie[0]} + {1'b0, tie[1]} + {1'b0, tie[2]});
        k    = lfsr[1:0] % ntie;
        pred = 2'd0;
        seen = 2'd0;
        for (int j = 0; j < 3; j++) begin
            if (tie[j]) begin
                if (seen == k) pred = 2'(j);
                seen = seen + 2'd1;
            end
        end
    end
`else
    logic unused_seed;
    logic m0, m1, m2;

    assign unused_seed = ^LFSR_SEED;

    always_comb begin
        m0   = (r0 >= r1) && (r0 >= r2);
        m1   = !m0 && (r1 >= r2);
        m2   = !m0 && !m1;
        pred = 2'd0;
        unique case (1'b1)
            m0:      pred = 2'd0;
            m1:      pred = 2'd1;
            m2:      pred = 2'd2;
            default: pred = 2'd0;
        endcase
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            tbl              <= '0;
            prev_move        <= 2'b00;
            cur              <= 2'b00;
            have_prev        <= 1'b0;
            bus.ready        <= 1'b1;
            bus.choice       <= 2'b00;
            bus.choice_valid <= 1'b0;
            bus.invalid_move <= 1'b0;
        end else begin
            bus.choice_valid <= 1'b0;
            bus.invalid_move <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.round_valid) begin
                        if (bus.user_move == 2'b11) begin
                            bus.invalid_move <= 1'b1;
                        end else begin
                            cur       <= bus.user_move;
                            state     <= UPDATE;
                            bus.ready <= 1'b0;
                        end
                    end
                end
                UPDATE: begin
                    // Saturation halves the whole row so relative odds survive.
                    if (have_prev) begin
                        for (int j = 0; j < 3; j++) begin
                            if (sat) begin
                                tbl[pbase + 4'(j)] <= (2'(j) == cur)
                                    ? (tbl[pbase + 4'(j)] >> 1) + COUNT_W'(1)
                                    : (tbl[pbase + 4'(j)] >> 1);
                            end else if (2'(j) == cur) begin
                                tbl[pbase + 4'(j)] <= tbl[pbase + 4'(j)] + COUNT_W'(1);
                            end
                        end
                    end
                    prev_move <= cur;
                    have_prev <= 1'b1;
                    state     <= PREDICT;
                end
                PREDICT: begin
                    bus.choice       <= beater(pred);
                    bus.choice_valid <= 1'b1;
                    bus.ready        <= 1'b1;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
